// File: rtl/iob_counter_ud_mod.sv
// iob_counter_ud_mod
// Up/down modulo counter with runtime step, inclusive upper limit, synchronous
// load and wrap/saturate boundary handling. tc_o pulses for one cycle, in step
// with data_o, whenever a step crosses a bound and is wrapped or clamped.
module iob_counter_ud_mod #(
  parameter int                 DATA_W  = 21,
  parameter logic [DATA_W-1:0]  RST_VAL = {DATA_W{1'b0}}
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              up_i,
  input  logic              ld_i,
  input  logic [DATA_W-1:0] ld_val_i,
  input  logic [DATA_W-1:0] step_i,
  input  logic [DATA_W-1:0] max_i,
  input  logic              sat_i,
  output logic [DATA_W-1:0] data_o,
  output logic              tc_o
);

  // What the counter does on an enabled (cke_i=1, no reset) edge.
  typedef enum logic [1:0] {
    ACT_HOLD = 2'd0,
    ACT_LOAD = 2'd1,
    ACT_STEP = 2'd2
  } act_t;

  // One extra bit so max_i+1 keeps its carry when max_i is all ones and so
  // data_o+step_i never truncates before the overflow compare.
  localparam int EXT_W = DATA_W + 1;

  logic [EXT_W-1:0] cur_ext;
  logic [EXT_W-1:0] step_ext;
  logic [EXT_W-1:0] max_ext;
  logic [EXT_W-1:0] mod_ext;
  logic [EXT_W-1:0] up_sum;
  logic [EXT_W-1:0] up_wrap;
  logic [EXT_W-1:0] dn_diff;
  logic [EXT_W-1:0] dn_wrap;
  logic             up_ovf;
  logic             dn_unf;

  act_t             act;
  logic [DATA_W-1:0] data_nxt;
  logic              tc_nxt;

  // Zero-extended operands and every candidate result; all are plain
  // arithmetic on known inputs, so out-of-range cases yield defined bits.
  assign cur_ext  = {1'b0, data_o};
  assign step_ext = {1'b0, step_i};
  assign max_ext  = {1'b0, max_i};
  assign mod_ext  = max_ext + {{DATA_W{1'b0}}, 1'b1};

  assign up_sum   = cur_ext + step_ext;
  assign up_ovf   = (up_sum > max_ext);
  assign up_wrap  = up_sum - mod_ext;

  assign dn_unf   = (step_ext > cur_ext);
  assign dn_diff  = cur_ext - step_ext;
  assign dn_wrap  = cur_ext + mod_ext - step_ext;

  // Priority decode of the per-edge action: load beats count beats hold.
  always_comb begin
    act = ACT_HOLD;
    if (ld_i) begin
      act = ACT_LOAD;
    end else if (en_i) begin
      act = ACT_STEP;
    end
  end

  // Next count and terminal-count value for the decoded action.
  always_comb begin
    // NOTE: every output of this block gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    data_nxt = data_o;
    tc_nxt   = 1'b0;
    unique case (act)
      ACT_LOAD: begin
        data_nxt = ld_val_i;
      end
      ACT_STEP: begin
        if (up_i) begin
          if (up_ovf) begin
            tc_nxt   = 1'b1;
            data_nxt = sat_i ? max_i : up_wrap[DATA_W-1:0];
          end else begin
            data_nxt = up_sum[DATA_W-1:0];
          end
        end else begin
          if (dn_unf) begin
            tc_nxt   = 1'b1;
            data_nxt = sat_i ? {DATA_W{1'b0}} : dn_wrap[DATA_W-1:0];
          end else begin
            data_nxt = dn_diff[DATA_W-1:0];
          end
        end
      end
      default: begin
        data_nxt = data_o;
      end
    endcase
  end

  // State register: reset wins over clock enable; cke_i=0 freezes both outputs.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst_i) begin
      data_o <= RST_VAL;
      tc_o   <= 1'b0;
    end else if (cke_i) begin
      data_o <= data_nxt;
      tc_o   <= tc_nxt;
    end
  end

endmodule
